// File: rtl/hk_spi_passthru_if.sv
// Host-side SPI bus of the housekeeping slave: clock, select, data in/out
// and the output-enable that tells the pad when sdo is being driven.
interface hk_spi_passthru_if;
  logic sck;
  logic csb;
  logic sdi;
  logic sdo;
  logic sdo_oe;

  modport master (output sck, output csb, output sdi, input sdo, input sdo_oe);
  modport slave  (input sck, input csb, input sdi, output sdo, output sdo_oe);
endinterface

// File: rtl/hk_spi_passthru.sv
// Housekeeping SPI slave sampled on the system clock. Holds a small ID and
// control register file, drives cpu_reset, and can hand the host SPI bus
// straight through to an external user flash.
module hk_spi_passthru #(
  parameter logic [11:0] MFGR_ID    = 12'h456,
  parameter logic [7:0]  PRODUCT_ID = 8'h11,
  parameter logic [31:0] USER_ID    = 32'h0
) (
  input  logic               clock,
  input  logic               resetb,
  hk_spi_passthru_if.slave   spi,
  output logic               pt_csb,
  output logic               pt_sck,
  output logic               pt_sdo,
  input  logic               pt_sdi,
  output logic               pt_active,
  output logic               cpu_reset
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, PASS, HOLD} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sck_q;
  logic [1:0]  csb_q;
  logic [1:0]  sdi_q;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        oe_q, oe_d;
  logic        pt_q, pt_d;
  logic [7:0]  s8_q, s8_d, s9_q, s9_d, sa_q, sa_d;
  logic        r0b_q, r0b_d;

  logic        sck_s, csb_s, sdi_s, sck_rise, last_bit;
  logic [7:0]  rx_byte;

  // Register-file read mux; unmapped addresses read zero.
  function automatic logic [7:0] rd_byte(input logic [7:0] a);
    case (a)
      8'h01:   rd_byte = {4'h0, MFGR_ID[11:8]};
      8'h02:   rd_byte = MFGR_ID[7:0];
      8'h03:   rd_byte = PRODUCT_ID;
      8'h04:   rd_byte = USER_ID[31:24];
      8'h05:   rd_byte = USER_ID[23:16];
      8'h06:   rd_byte = USER_ID[15:8];
      8'h07:   rd_byte = USER_ID[7:0];
      8'h08:   rd_byte = s8_q;
      8'h09:   rd_byte = s9_q;
      8'h0A:   rd_byte = sa_q;
      8'h0B:   rd_byte = {7'h00, r0b_q};
      default: rd_byte = 8'h00;
    endcase
  endfunction

  assign sck_s    = sck_q[1];
  assign csb_s    = csb_q[1];
  assign sdi_s    = sdi_q[1];
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign last_bit = (cnt_q == 3'd7);
  assign rx_byte  = {rx_q, sdi_s};

  // Two-flop synchronizers for the asynchronous host pins, plus one extra
  // sck stage for rising-edge detection.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sck_q <= 3'b000;
      csb_q <= 2'b11;
      sdi_q <= 2'b00;
    end else begin
      sck_q <= {sck_q[1:0], spi.sck};
      csb_q <= {csb_q[0], spi.csb};
      sdi_q <= {sdi_q[0], spi.sdi};
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rx_q    <= 7'd0;
      tx_q    <= 8'd0;
      addr_q  <= 8'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      oe_q    <= 1'b0;
      pt_q    <= 1'b0;
      s8_q    <= 8'd0;
      s9_q    <= 8'd0;
      sa_q    <= 8'd0;
      r0b_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      oe_q    <= oe_d;
      pt_q    <= pt_d;
      s8_q    <= s8_d;
      s9_q    <= s9_d;
      sa_q    <= sa_d;
      r0b_q   <= r0b_d;
    end
  end

  // Frame sequencing: byte assembly, command decode, register access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    oe_d    = oe_q;
    pt_d    = pt_q;
    s8_d    = s8_q;
    s9_d    = s9_q;
    sa_d    = sa_q;
    r0b_d   = r0b_q;

    if (csb_s) begin
      // Deselect abandons any partial byte but keeps register contents.
      state_d = IDLE;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      pt_d    = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = CMD;
    end else if (sck_rise) begin
      cnt_d = cnt_q + 3'd1;
      rx_d  = rx_byte[6:0];
      if (state_q == DATA && oe_q)
        tx_d = {tx_q[6:0], 1'b0};
      if (last_bit) begin
        case (state_q)
          CMD: begin
            case (rx_byte)
              8'h80:   begin wr_d = 1'b1; rd_d = 1'b0; state_d = ADDR; end
              8'h40:   begin wr_d = 1'b0; rd_d = 1'b1; state_d = ADDR; end
              8'hC0:   begin wr_d = 1'b1; rd_d = 1'b1; state_d = ADDR; end
              8'hC2:   begin pt_d = 1'b1; state_d = PASS; end
              default: state_d = HOLD;
            endcase
          end
          ADDR: begin
            addr_d  = rx_byte;
            state_d = DATA;
            if (rd_q) begin
              tx_d = rd_byte(rx_byte);
              oe_d = 1'b1;
            end
          end
          DATA: begin
            // Write lands on the byte's own address; read-back preloads the
            // following address, so read/write mode writes back in place.
            if (wr_q) begin
              case (addr_q)
                8'h08:   s8_d  = rx_byte;
                8'h09:   s9_d  = rx_byte;
                8'h0A:   sa_d  = rx_byte;
                8'h0B:   r0b_d = rx_byte[0];
                default: ;
              endcase
            end
            addr_d = addr_q + 8'd1;
            if (rd_q)
              tx_d = rd_byte(addr_q + 8'd1);
          end
          default: ;
        endcase
      end
    end
  end

  // Pass-thru is a purely combinational path gated by the engaged flag.
  assign pt_active  = pt_q;
  assign pt_csb     = ~pt_q;
  assign pt_sck     = spi.sck & pt_q;
  assign pt_sdo     = spi.sdi & pt_q;
  assign spi.sdo    = pt_q ? pt_sdi : (oe_q & tx_q[7]);
  assign spi.sdo_oe = pt_q | oe_q;
  assign cpu_reset  = r0b_q;

endmodule

// File: tb/tb_hk_spi_passthru.sv
// Directed bench for the housekeeping SPI slave, with a small SPI flash
// model hanging off the pass-thru pins.
module tb_hk_spi_passthru;
  localparam int HALF = 6;

  logic clock = 1'b0;
  logic resetb = 1'b0;
  always #5 clock = ~clock;

  hk_spi_passthru_if spi();
  logic pt_csb, pt_sck, pt_sdo, pt_sdi, pt_active, cpu_reset;

  hk_spi_passthru dut (
    .clock(clock), .resetb(resetb), .spi(spi),
    .pt_csb(pt_csb), .pt_sck(pt_sck), .pt_sdo(pt_sdo), .pt_sdi(pt_sdi),
    .pt_active(pt_active), .cpu_reset(cpu_reset)
  );

  int total = 0;
  int bad = 0;
  int ptlow_cnt = 0;

  // Flash model: read command 0x03 with a 24-bit address, mode 0.
  logic [7:0]  fmem [8];
  logic        f_sck_d = 1'b0, f_csb_d = 1'b1, f_sdo = 1'b0;
  int          f_n = 0;
  logic [7:0]  f_cmd = 8'h00;
  logic [23:0] f_addr = 24'h0;

  function automatic logic fbit(input int i);
    int b;
    b = (int'(f_addr[2:0]) + i / 8) % 8;
    return fmem[b][7 - (i % 8)];
  endfunction

  always @(posedge clock) begin
    f_sck_d <= pt_sck;
    f_csb_d <= pt_csb;
    if (pt_csb) begin
      f_n   <= 0;
      f_sdo <= 1'b0;
    end else if (!f_csb_d) begin
      if (pt_sck && !f_sck_d) begin
        f_n <= f_n + 1;
        if (f_n < 8) f_cmd <= {f_cmd[6:0], pt_sdo};
        else if (f_n < 32) f_addr <= {f_addr[22:0], pt_sdo};
      end
      if (!pt_sck && f_sck_d && f_n >= 32 && f_cmd == 8'h03)
        f_sdo <= fbit(f_n - 32);
    end
  end
  assign pt_sdi = f_sdo;

  always @(negedge clock) if (pt_csb === 1'b0) ptlow_cnt <= ptlow_cnt + 1;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic frame_start();
    spi.csb = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic frame_end();
    spi.sck = 1'b0;
    spi.sdi = 1'b0;
    wait_clk(HALF);
    spi.csb = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi.sdi = tx[i];
      wait_clk(HALF);
      rx[i] = spi.sdo;
      spi.sck = 1'b1;
      wait_clk(HALF);
      spi.sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic test_reset();
    spi.csb = 1'b1; spi.sck = 1'b1; spi.sdi = 1'b1;
    resetb = 1'b0;
    wait_clk(3);
    total++; if (spi.sdo !== 1'b0) begin bad++; $display("FAIL rst_sdo got=%b want=0", spi.sdo); end
    total++; if (spi.sdo_oe !== 1'b0) begin bad++; $display("FAIL rst_sdo_oe got=%b want=0", spi.sdo_oe); end
    total++; if (pt_csb !== 1'b1) begin bad++; $display("FAIL rst_pt_csb got=%b want=1", pt_csb); end
    total++; if (pt_sck !== 1'b0) begin bad++; $display("FAIL rst_pt_sck got=%b want=0", pt_sck); end
    total++; if (pt_sdo !== 1'b0) begin bad++; $display("FAIL rst_pt_sdo got=%b want=0", pt_sdo); end
    total++; if (pt_active !== 1'b0) begin bad++; $display("FAIL rst_pt_active got=%b want=0", pt_active); end
    total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL rst_cpu_reset got=%b want=0", cpu_reset); end
    spi.sck = 1'b0; spi.sdi = 1'b0;
    wait_clk(2);
    resetb = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_read_id();
    logic [7:0] rx;
    frame_start();
    spi_byte(8'h40, rx);
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    total++; if (rx !== 8'h11) begin bad++; $display("FAIL read_product got=%h want=11", rx); end
    total++; if (spi.sdo_oe !== 1'b1) begin bad++; $display("FAIL read_oe got=%b want=1", spi.sdo_oe); end
    frame_end();
    total++; if (spi.sdo_oe !== 1'b0) begin bad++; $display("FAIL idle_oe got=%b want=0", spi.sdo_oe); end
  endtask

  task automatic test_read_stream();
    logic [7:0] rx;
    logic [7:0] exp [3];
    exp = '{8'h04, 8'h56, 8'h11};
    frame_start();
    spi_byte(8'h40, rx);
    spi_byte(8'h01, rx);
    for (int i = 0; i < 3; i++) begin
      spi_byte(8'h00, rx);
      total++; if (rx !== exp[i]) begin bad++; $display("FAIL stream_%0d got=%h want=%h", i, rx, exp[i]); end
    end
    frame_end();
  endtask

  task automatic test_write_scratch();
    logic [7:0] rx;
    frame_start();
    spi_byte(8'h80, rx); spi_byte(8'h08, rx); spi_byte(8'hA5, rx); spi_byte(8'h5A, rx);
    frame_end();
    frame_start();
    spi_byte(8'h40, rx); spi_byte(8'h08, rx);
    spi_byte(8'h00, rx);
    total++; if (rx !== 8'hA5) begin bad++; $display("FAIL scratch08 got=%h want=a5", rx); end
    spi_byte(8'h00, rx);
    total++; if (rx !== 8'h5A) begin bad++; $display("FAIL scratch09 got=%h want=5a", rx); end
    frame_end();
    // Write to a read-only ID register is ignored; unmapped reads are zero.
    frame_start();
    spi_byte(8'h80, rx); spi_byte(8'h03, rx); spi_byte(8'hFF, rx);
    frame_end();
    frame_start();
    spi_byte(8'h40, rx); spi_byte(8'h03, rx); spi_byte(8'h00, rx);
    total++; if (rx !== 8'h11) begin bad++; $display("FAIL ro_write got=%h want=11", rx); end
    frame_end();
    frame_start();
    spi_byte(8'h80, rx); spi_byte(8'h20, rx); spi_byte(8'hFF, rx);
    frame_end();
    frame_start();
    spi_byte(8'h40, rx); spi_byte(8'h20, rx); spi_byte(8'h00, rx);
    total++; if (rx !== 8'h00) begin bad++; $display("FAIL unmapped got=%h want=00", rx); end
    frame_end();
  endtask

  task automatic test_read_write();
    logic [7:0] rx;
    frame_start();
    spi_byte(8'hC0, rx); spi_byte(8'h09, rx);
    spi_byte(8'h77, rx);
    total++; if (rx !== 8'h5A) begin bad++; $display("FAIL rw_old09 got=%h want=5a", rx); end
    spi_byte(8'h3C, rx);
    total++; if (rx !== 8'h00) begin bad++; $display("FAIL rw_old0a got=%h want=00", rx); end
    frame_end();
    frame_start();
    spi_byte(8'h40, rx); spi_byte(8'h09, rx);
    spi_byte(8'h00, rx);
    total++; if (rx !== 8'h77) begin bad++; $display("FAIL rw_new09 got=%h want=77", rx); end
    spi_byte(8'h00, rx);
    total++; if (rx !== 8'h3C) begin bad++; $display("FAIL rw_new0a got=%h want=3c", rx); end
    frame_end();
  endtask

  task automatic test_bad_cmd();
    logic [7:0] rx;
    frame_start();
    spi_byte(8'h12, rx); spi_byte(8'h40, rx); spi_byte(8'h03, rx); spi_byte(8'h00, rx);
    total++; if (rx !== 8'h00) begin bad++; $display("FAIL hold_data got=%h want=00", rx); end
    total++; if (spi.sdo_oe !== 1'b0) begin bad++; $display("FAIL hold_oe got=%b want=0", spi.sdo_oe); end
    frame_end();
  endtask

  task automatic test_passthru();
    logic [7:0] rx;
    logic [7:0] exp [8];
    int c0;
    exp = '{8'h6F, 8'h00, 8'h00, 8'h0B, 8'h93, 8'h01, 8'h00, 8'h00};
    c0 = ptlow_cnt;
    frame_start();
    total++; if (pt_csb !== 1'b1) begin bad++; $display("FAIL pt_pre_csb got=%b want=1", pt_csb); end
    spi_byte(8'hC2, rx);
    total++; if (pt_active !== 1'b1) begin bad++; $display("FAIL pt_active got=%b want=1", pt_active); end
    total++; if (pt_csb !== 1'b0) begin bad++; $display("FAIL pt_csb_low got=%b want=0", pt_csb); end
    total++; if (spi.sdo_oe !== 1'b1) begin bad++; $display("FAIL pt_oe got=%b want=1", spi.sdo_oe); end
    spi.sdi = 1'b1; spi.sck = 1'b1;
    wait_clk(HALF);
    total++; if (pt_sck !== 1'b1) begin bad++; $display("FAIL pt_sck_follow got=%b want=1", pt_sck); end
    total++; if (pt_sdo !== 1'b1) begin bad++; $display("FAIL pt_sdo_follow got=%b want=1", pt_sdo); end
    spi.sck = 1'b0;
    spi_bits(8'hFF, 7, rx);
    frame_end();
    total++; if (pt_csb !== 1'b1) begin bad++; $display("FAIL pt_csb_end got=%b want=1", pt_csb); end
    total++; if (pt_active !== 1'b0) begin bad++; $display("FAIL pt_active_end got=%b want=0", pt_active); end
    frame_start();
    spi_byte(8'hC2, rx); spi_byte(8'hAB, rx);
    frame_end();
    frame_start();
    spi_byte(8'hC2, rx); spi_byte(8'h03, rx);
    spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx);
    for (int i = 0; i < 8; i++) begin
      spi_byte(8'h00, rx);
      total++; if (rx !== exp[i]) begin bad++; $display("FAIL flash_%0d got=%h want=%h", i, rx, exp[i]); end
    end
    frame_end();
    total++; if (pt_sck !== 1'b0) begin bad++; $display("FAIL pt_sck_idle got=%b want=0", pt_sck); end
    total++; if (ptlow_cnt == c0) begin bad++; $display("FAIL pt_csb_seen got=%0d want>%0d", ptlow_cnt, c0); end
    // Registers are untouched by the pass-thru frames.
    frame_start();
    spi_byte(8'h40, rx); spi_byte(8'h08, rx);
    spi_byte(8'h00, rx);
    total++; if (rx !== 8'hA5) begin bad++; $display("FAIL pt_keep08 got=%h want=a5", rx); end
    spi_byte(8'h00, rx);
    total++; if (rx !== 8'h77) begin bad++; $display("FAIL pt_keep09 got=%h want=77", rx); end
    spi_byte(8'h00, rx);
    total++; if (rx !== 8'h3C) begin bad++; $display("FAIL pt_keep0a got=%h want=3c", rx); end
    frame_end();
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    int c0;
    c0 = ptlow_cnt;
    frame_start();
    spi_byte(8'h40, rx);
    spi_bits(8'h03, 4, rx);
    frame_end();
    frame_start();
    spi_byte(8'h80, rx); spi_byte(8'h08, rx);
    spi_bits(8'hFF, 4, rx);
    frame_end();
    frame_start();
    spi_byte(8'h40, rx); spi_byte(8'h03, rx); spi_byte(8'h00, rx);
    total++; if (rx !== 8'h11) begin bad++; $display("FAIL abort_read got=%h want=11", rx); end
    frame_end();
    frame_start();
    spi_byte(8'h40, rx); spi_byte(8'h08, rx); spi_byte(8'h00, rx);
    total++; if (rx !== 8'hA5) begin bad++; $display("FAIL abort_write got=%h want=a5", rx); end
    frame_end();
    total++; if (ptlow_cnt != c0) begin bad++; $display("FAIL abort_pt_csb got=%0d want=%0d", ptlow_cnt, c0); end
  endtask

  task automatic test_reset_ctrl();
    logic [7:0] rx;
    frame_start();
    spi_byte(8'h80, rx); spi_byte(8'h0B, rx); spi_byte(8'h01, rx);
    frame_end();
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL cpu_reset_set got=%b want=1", cpu_reset); end
    frame_start();
    spi_byte(8'h40, rx); spi_byte(8'h0B, rx); spi_byte(8'h00, rx);
    total++; if (rx !== 8'h01) begin bad++; $display("FAIL reg0b_read got=%h want=01", rx); end
    frame_end();
    frame_start();
    spi_byte(8'h80, rx); spi_byte(8'h0B, rx); spi_byte(8'h00, rx);
    frame_end();
    total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL cpu_reset_clr got=%b want=0", cpu_reset); end
    frame_start();
    spi_byte(8'h80, rx); spi_byte(8'h0B, rx); spi_byte(8'h01, rx);
    frame_end();
    // Reset in the middle of a read so sdo_oe is live when it hits.
    frame_start();
    spi_byte(8'h40, rx); spi_byte(8'h08, rx);
    spi_bits(8'h00, 3, rx);
    total++; if (spi.sdo_oe !== 1'b1) begin bad++; $display("FAIL mid_oe got=%b want=1", spi.sdo_oe); end
    resetb = 1'b0;
    wait_clk(2);
    total++; if (spi.sdo_oe !== 1'b0) begin bad++; $display("FAIL mid_rst_oe got=%b want=0", spi.sdo_oe); end
    total++; if (spi.sdo !== 1'b0) begin bad++; $display("FAIL mid_rst_sdo got=%b want=0", spi.sdo); end
    total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL mid_rst_cpu got=%b want=0", cpu_reset); end
    total++; if (pt_csb !== 1'b1) begin bad++; $display("FAIL mid_rst_pt_csb got=%b want=1", pt_csb); end
    total++; if (pt_active !== 1'b0) begin bad++; $display("FAIL mid_rst_pt_active got=%b want=0", pt_active); end
    spi.csb = 1'b1; spi.sck = 1'b0; spi.sdi = 1'b0;
    wait_clk(2);
    resetb = 1'b1;
    wait_clk(4);
    frame_start();
    spi_byte(8'h40, rx); spi_byte(8'h08, rx);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, rx);
      total++; if (rx !== 8'h00) begin bad++; $display("FAIL post_rst_reg%0d got=%h want=00", 8 + i, rx); end
    end
    frame_end();
  endtask

  initial begin
    fmem = '{8'h6F, 8'h00, 8'h00, 8'h0B, 8'h93, 8'h01, 8'h00, 8'h00};
    spi.csb = 1'b1; spi.sck = 1'b0; spi.sdi = 1'b0;
    test_reset();
    test_read_id();
    test_read_stream();
    test_write_scratch();
    test_read_write();
    test_bad_cmd();
    test_passthru();
    test_abort();
    test_reset_ctrl();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hk_spi_passthru.md
Name: hk_spi_passthru

Overview:
- Housekeeping SPI slave for the management SoC, sampled on the system clock.
- Provides a small ID/control register file readable and writable over SPI.
- Drives a CPU reset control output.
- Offers a user pass-thru mode that connects the host SPI straight through to an external user SPI flash (user_csb/user_clk/user_io0/user_io1 pads).

Parameters:
- MFGR_ID, 12'h456, manufacturer ID. Reg 0x01 reads {4'h0, MFGR_ID[11:8]}; reg 0x02 reads MFGR_ID[7:0].
- PRODUCT_ID, 8'h11, product ID returned at reg 0x03.
- USER_ID, 32'h0, user project ID returned MSB-first at regs 0x04-0x07.

Ports:
- clock  in  1  system clock; all state on rising edge.
- resetb  in  1  asynchronous active-low reset.
- sck  in  1  host SPI clock, asynchronous.
- csb  in  1  host SPI chip select, active low, asynchronous.
- sdi  in  1  host SPI data in.
- sdo  out  1  host SPI data out.
- sdo_oe  out  1  high while sdo is driven (register read data or pass-thru).
- pt_csb  out  1  pass-thru flash chip select.
- pt_sck  out  1  pass-thru flash clock.
- pt_sdo  out  1  pass-thru data to flash.
- pt_sdi  in  1  pass-thru data from flash.
- pt_active  out  1  high while pass-thru mode is engaged.
- cpu_reset  out  1  reg 0x0B bit0, active high.

Behaviour:
- Sync: sck, csb and sdi each pass through a 2-FF synchronizer. SCK rising edge is detected from the synced samples.
  - Host SCK high and low phases are each at least 4 clock cycles.
  - SPI mode 0, MSB first.
- Reset (resetb=0): state IDLE, regs 0x08-0x0B = 0, cpu_reset=0, sdo=0, sdo_oe=0, pt_csb=1, pt_sck=0, pt_sdo=0, pt_active=0.
- Synced csb=1 at any time: return to IDLE, clear bit count, sdo_oe=0, pt_active=0. Register contents are kept. An aborted partial byte has no effect.
- States: IDLE -> CMD on csb low. In each state, 8 SCK rising edges shift in one byte.
- Command byte (CMD state):
  - 0x80: write stream; next state ADDR.
  - 0x40: read stream; next state ADDR.
  - 0xC0: read/write stream; next state ADDR.
  - 0xC2: user pass-thru; next state PASS.
  - Any other value: HOLD; ignore the rest of the frame until csb rises.
- ADDR state: the next byte latches an 8-bit address. Next state is DATA.
- DATA state, per 8-bit byte:
  - Write: on the 8th rising edge, write the received byte to the current address, then increment the address (wraps 0xFF -> 0x00).
  - Read:
    - The shift register is loaded from the current address within 3 clocks of the rising edge that completes the preceding byte (address or data). Its MSB is driven on sdo at once.
    - Each later SCK rising edge advances sdo to the next bit within 3 clocks.
    - The address increments after each byte is loaded.
  - 0xC0 (read/write): each byte is read out, and the received byte is written back to the same address.
- Register map:
  - 0x00: 0x00, read-only.
  - 0x01/0x02: manufacturer ID, read-only.
  - 0x03: PRODUCT_ID, read-only.
  - 0x04-0x07: USER_ID, read-only.
  - 0x08-0x0A: scratch, read/write.
  - 0x0B: bit0 = cpu_reset, read/write; upper bits read 0.
  - Unmapped addresses read 0x00; writes to them are ignored.
- PASS state:
  - pt_active=1 and pt_csb=0 from within 3 clocks after the 8th command bit until synced csb=1.
  - Data path is combinational, gated only by pt_active: pt_sck = sck & pt_active, pt_sdo = sdi, sdo = pt_sdi, sdo_oe=1.
  - When pt_active drops: pt_csb=1, pt_sck=0.
  - The register file is untouched in pass-thru.
- sdo outside read or pass-thru: 0, with sdo_oe=0.

Test Plan:
- Read product ID: csb low, send 0x40, 0x03, clock 8 bits, csb high -> received 0x11.
- Read stream: 0x40, 0x01, read 3 bytes -> 0x04, 0x56, 0x11.
- Write/read scratch: 0x80, 0x08, 0xA5, 0x5A; then 0x40, 0x08, read 2 bytes -> 0xA5, 0x5A.
- Reset control: 0x80, 0x0B, 0x01 -> cpu_reset=1 after the frame. Then 0x80, 0x0B, 0x00 -> cpu_reset=0. Then assert resetb mid-frame -> all outputs at reset values, scratch regs = 0.
- Pass-thru with a flash model holding 6F 00 00 0B 93 01 00 00 at address 0:
  - Frames 0xC2, 0xFF and 0xC2, 0xAB complete with no register change.
  - Frame 0xC2, 0x03, 00 00 00, then 8 read bytes -> 6F 00 00 0B 93 01 00 00.
  - pt_csb=0 only during each frame.
- Abort: raise csb after 4 bits of an address byte, then a fresh frame 0x40, 0x03 -> 0x11. pt_csb stays high throughout.
